keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
Scans a 4x4 matrix keypad and turns it into debounced key events for the multiplier front panel. It is the input-side counterpart of the time-multiplexed 7-segment display drive. It drives one active-low column at a time and samples the active-low row lines. Its outputs are a 4-bit key code, a one-cycle press strobe, and level status flags for the operand-entry logic.

Parameters:
SCAN_BITS, 17, column dwell = 2^SCAN_BITS clk cycles (1.31 ms at 100 MHz); legal range >= 3
DEBOUNCE_FRAMES, 4, consecutive identical full-scan frames needed to accept a press or a release; legal range 1..15

Ports:
clk  input  1  system clock, 100 MHz
rst  input  1  asynchronous, active-high reset
row_n  input  4  keypad rows, active low, externally pulled up, asynchronous to clk
col_n  output  4  keypad column drive, active low, exactly one bit low at all times
key_code  output  4  last accepted key = {row_idx[1:0], col_idx[1:0]}
key_valid  output  1  one-cycle strobe on an accepted press
key_held  output  1  high while the accepted key is debounced-down
multi_key  output  1  high when the last completed frame saw 2 or more keys

Behaviour:
- Reset (async, rst=1): col_n=4'b1110, key_code=0, key_valid=0, key_held=0, multi_key=0.
  - Also on reset: synchronizer flops=4'b1111, dwell counter=0, column index=0, frame image=0, FSM=IDLE, debounce counter=0.
- Synchronizer: row_n passes through 2 flops before any use.
- Scan timing:
  - Dwell counter is SCAN_BITS wide and free-running.
  - When it wraps from all-ones to 0, the column index (2 bits) increments, wrapping 3->0.
  - col_n = ~(4'b0001 << col_idx), registered.
- Sampling:
  - On the last dwell cycle (counter all-ones), the synchronized rows are inverted and stored into frame image bits [col_idx*4 +: 4].
  - Bit col*4+r set means key (r,c) is down.
  - The remaining dwell cycles give the matrix settle time and cover the synchronizer latency.
- Frame end: the sample cycle of column 3. The classification below uses the 16-bit image including that column's bits. Classes:
  - NONE: popcount 0.
  - SINGLE(k): popcount 1, k = {r,c}.
  - MULTI: popcount >= 2.
- multi_key is registered at every frame end: 1 iff MULTI.
- Debounce FSM advances only at frame end. DEBOUNCE_FRAMES is abbreviated D. States:
  - IDLE:
    - SINGLE(k): cand=k, cnt=1. If D==1, go to PRESSED with an accept; otherwise go to CAND.
    - NONE/MULTI: stay.
  - CAND:
    - SINGLE(cand): cnt+1. When cnt reaches D, go to PRESSED with an accept.
    - SINGLE(other): cand=other, cnt=1.
    - NONE/MULTI: go to IDLE, cnt=0.
  - Accept: key_code<=cand, key_held<=1, key_valid=1 for exactly the cycle after frame end.
  - PRESSED:
    - Frame containing key_code's bit (alone or in MULTI): rcnt=0, stay.
    - Frame lacking it: rcnt+1. When rcnt reaches D, go to IDLE with key_held<=0.
    - No key_valid while PRESSED, even if another key is added.
- key_code holds its value until the next accept. It is never cleared by release.
- Press latency: accept occurs at the end of the D-th full frame in which the key is steadily down. One frame = 4*2^SCAN_BITS cycles.
- Reset asserted mid-frame or mid-debounce aborts everything immediately. No key_valid is emitted during reset or on the cycle it releases.
- key_valid never asserts on two consecutive cycles. There is at most one strobe per press.

Test Plan:
Bench settings: SCAN_BITS=4 (dwell 16 cycles, frame 64 cycles), DEBOUNCE_FRAMES=3. The keypad model drives row_n[r]=0 iff key(r,c) is pressed and col_n[c]=0.
1. Reset, then idle 200 cycles -> all outputs at reset values; col_n sequence 1110 -> 1101 (cycle 16) -> 1011 -> 0111 -> 1110 (cycle 64); key_valid never high.
2. Press key (row2,col1) steadily from cycle 0 -> single key_valid pulse with key_code=4'b1001 one cycle after the 3rd frame end; key_held=1; multi_key=0.
3. Toggle key (row2,col1) on/off every alternate frame for 20 frames -> no key_valid, key_held stays 0.
4. Hold (row0,col3) and (row1,col3) together -> multi_key=1 after the first frame end, no key_valid. Release (row1,col3) -> multi_key=0 next frame, and key_valid with key_code=4'b0011 after 3 single frames.
5. Accept (row3,col0), then release -> key_held falls after 3 frames without the key; code stays 4'b1100. Re-press -> new single key_valid.
6. Press (row1,col2) and assert rst during the 2nd frame for 5 cycles -> outputs at reset values, col_n=1110. Keep holding after rst is released -> key_valid only after 3 fresh full frames, key_code=4'b0110.

Source files
------------

// File: rtl/keypad_scanner_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | keypad_scanner_if : keypad matrix lines and debounced key outputs  |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
interface keypad_scanner_if;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic       multi_key;

  modport master (
    input  row_n,
    output col_n,
    output key_code,
    output key_valid,
    output key_held,
    output multi_key
  );

  modport slave (
    output row_n,
    input  col_n,
    input  key_code,
    input  key_valid,
    input  key_held,
    input  multi_key
  );
endinterface
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | keypad_scanner : 4x4 matrix scan with frame-based debounce         |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module keypad_scanner #(
  parameter int SCAN_BITS       = 17,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic              clk,
  input  logic              rst,
  keypad_scanner_if.master  kp_io
);

  localparam logic [3:0]           D_CNT    = 4'(DEBOUNCE_FRAMES);
  localparam logic [SCAN_BITS-1:0] DWELL_ONE = {{(SCAN_BITS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAND    = 2'd1,
    PRESSED = 2'd2
  } state_t;

  logic [3:0]           row_meta_q;
  logic [3:0]           row_sync_q;
  logic [SCAN_BITS-1:0] dwell_q;
  logic [1:0]           col_idx_q;
  logic [1:0]           col_idx_d;
  logic [3:0]           col_n_q;
  logic [15:0]          frame_q;
  logic [15:0]          frame_d;
  state_t               state_q;
  state_t               state_d;
  logic [3:0]           cnt_q;
  logic [3:0]           cnt_d;
  logic [3:0]           cand_q;
  logic [3:0]           cand_d;
  logic [3:0]           key_code_q;
  logic [3:0]           key_code_d;
  logic                 key_held_q;
  logic                 key_held_d;
  logic                 key_valid_q;
  logic                 key_valid_d;
  logic                 multi_q;
  logic                 multi_d;

  logic                 last_dwell;
  logic                 frame_end;
  logic [4:0]           pop;
  logic [3:0]           single_code;
  logic                 is_single;
  logic                 held_seen;

  assign last_dwell = &dwell_q;
  assign frame_end  = last_dwell && (col_idx_q == 2'd3);
  assign col_idx_d  = last_dwell ? col_idx_q + 2'd1 : col_idx_q;

  // Image bit {col,row}; the frame-end classification sees column 3 via frame_d.
  always_comb begin
    frame_d = frame_q;
    if (last_dwell) begin
      frame_d[{col_idx_q, 2'b00} +: 4] = ~row_sync_q;
    end
  end

  always_comb begin
    pop         = 5'd0;
    single_code = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (frame_d[i]) begin
        pop         = pop + 5'd1;
        single_code = {i[1:0], i[3:2]};
      end
    end
  end

  assign is_single = (pop == 5'd1);
  assign held_seen = frame_d[{key_code_q[1:0], key_code_q[3:2]}];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    key_code_d  = key_code_q;
    key_held_d  = key_held_q;
    key_valid_d = 1'b0;
    multi_d     = multi_q;
    if (frame_end) begin
      multi_d = (pop >= 5'd2);
      case (state_q)
        IDLE: begin
          if (is_single) begin
            cand_d = single_code;
            cnt_d  = 4'd1;
            if (D_CNT == 4'd1) begin
              state_d     = PRESSED;
              cnt_d       = 4'd0;
              key_code_d  = single_code;
              key_held_d  = 1'b1;
              key_valid_d = 1'b1;
            end else begin
              state_d = CAND;
            end
          end
        end
        CAND: begin
          if (!is_single) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end else if (single_code == cand_q) begin
            cnt_d = cnt_q + 4'd1;
            if ((cnt_q + 4'd1) == D_CNT) begin
              state_d     = PRESSED;
              cnt_d       = 4'd0;
              key_code_d  = cand_q;
              key_held_d  = 1'b1;
              key_valid_d = 1'b1;
            end
          end else begin
            cand_d = single_code;
            cnt_d  = 4'd1;
          end
        end
        PRESSED: begin
          // Extra keys joining a held key never retrigger; only absence counts.
          if (held_seen) begin
            cnt_d = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
            if ((cnt_q + 4'd1) == D_CNT) begin
              state_d    = IDLE;
              cnt_d      = 4'd0;
              key_held_d = 1'b0;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_meta_q  <= 4'b1111;
      row_sync_q  <= 4'b1111;
      dwell_q     <= '0;
      col_idx_q   <= 2'd0;
      col_n_q     <= 4'b1110;
      frame_q     <= 16'd0;
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      cand_q      <= 4'd0;
      key_code_q  <= 4'd0;
      key_held_q  <= 1'b0;
      key_valid_q <= 1'b0;
      multi_q     <= 1'b0;
    end else begin
      row_meta_q  <= kp_io.row_n;
      row_sync_q  <= row_meta_q;
      dwell_q     <= dwell_q + DWELL_ONE;
      col_idx_q   <= col_idx_d;
      col_n_q     <= ~(4'b0001 << col_idx_d);
      frame_q     <= frame_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_code_q  <= key_code_d;
      key_held_q  <= key_held_d;
      key_valid_q <= key_valid_d;
      multi_q     <= multi_d;
    end
  end

  assign kp_io.col_n     = col_n_q;
  assign kp_io.key_code  = key_code_q;
  assign kp_io.key_valid = key_valid_q;
  assign kp_io.key_held  = key_held_q;
  assign kp_io.multi_key = multi_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_keypad_scanner : keypad matrix model with frame-level reference |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_keypad_scanner;

  localparam int SB = 4;
  localparam int D  = 3;
  localparam int FR = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] keys;      // bit r*4+c set = key (r,c) pressed; equals its key code
  logic [3:0]  row_drv;
  int          edges;
  int          checks   = 0;
  int          failures = 0;

  // Reference model state, advanced once per frame
  logic        m_held;
  logic [3:0]  m_code;
  logic [3:0]  m_run_key;
  int          m_run_len;
  int          m_miss;
  logic        m_multi;
  logic        m_valid;

  always #5 clk = ~clk;

  keypad_scanner_if kp();

  keypad_scanner #(
    .SCAN_BITS       (SB),
    .DEBOUNCE_FRAMES (D)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .kp_io (kp.master)
  );

  always_comb begin
    row_drv = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !kp.col_n[c]) row_drv[r] = 1'b0;
  end
  assign kp.row_n = row_drv;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_col(input int n);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << ((n / 16) % 4));
  endfunction

  function automatic logic [3:0] lowest_key(input logic [15:0] k);
    for (int i = 0; i < 16; i++) if (k[i]) return 4'(i);
    return 4'd0;
  endfunction

  task automatic model_reset();
    m_held = 1'b0; m_code = 4'd0; m_run_key = 4'd0;
    m_run_len = 0; m_miss = 0; m_multi = 1'b0; m_valid = 1'b0;
  endtask

  task automatic model_frame(input logic [15:0] k);
    int n;
    n       = $countones(k);
    m_valid = 1'b0;
    m_multi = (n >= 2);
    if (m_held) begin
      if (k[m_code]) m_miss = 0;
      else begin
        m_miss++;
        if (m_miss == D) begin m_held = 1'b0; m_miss = 0; m_run_len = 0; end
      end
    end else if (n == 1) begin
      if (m_run_len > 0 && lowest_key(k) == m_run_key) m_run_len++;
      else begin m_run_key = lowest_key(k); m_run_len = 1; end
      if (m_run_len == D) begin
        m_held = 1'b1; m_code = m_run_key; m_valid = 1'b1; m_run_len = 0; m_miss = 0;
      end
    end else begin
      m_run_len = 0;
    end
  endtask

  task automatic apply_reset(input int cyc);
    @(negedge clk);
    rst = 1'b1;
    repeat (cyc) @(negedge clk);
    chk("rst_col_n", kp.col_n, 4'b1110);
    chk("rst_code", kp.key_code, 4'd0);
    chk("rst_valid", kp.key_valid, 1'b0);
    chk("rst_held", kp.key_held, 1'b0);
    chk("rst_multi", kp.multi_key, 1'b0);
    rst   = 1'b0;
    edges = 0;
    model_reset();
  endtask

  task automatic run_frame(input logic [15:0] k);
    logic col_bad, kv_extra;
    keys     = k;
    col_bad  = 1'b0;
    kv_extra = 1'b0;
    for (int i = 1; i <= FR; i++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (kp.col_n !== exp_col(edges)) col_bad = 1'b1;
      if (i < FR && kp.key_valid !== 1'b0) kv_extra = 1'b1;
    end
    model_frame(k);
    chk("col_seq", col_bad, 1'b0);
    chk("valid_quiet", kv_extra, 1'b0);
    chk("key_valid", kp.key_valid, m_valid);
    chk("key_held", kp.key_held, m_held);
    chk("multi_key", kp.multi_key, m_multi);
    chk("key_code", kp.key_code, m_code);
  endtask

  initial begin
    logic [15:0] one;
    logic [15:0] pat;
    one  = 16'h0001;
    keys = 16'h0000;
    rst  = 1'b1;
    edges = 0;
    model_reset();

    // Idle scanning after reset
    apply_reset(3);
    repeat (4) run_frame(16'h0000);

    // Steady press of (2,1) from reset, then release
    keys = one << 9;
    apply_reset(2);
    repeat (3) run_frame(one << 9);
    chk("press_code", kp.key_code, 4'b1001);
    repeat (3) run_frame(16'h0000);

    // Bouncing key never accepted
    for (int f = 0; f < 20; f++) run_frame((f % 2 == 0) ? (one << 9) : 16'h0000);
    chk("bounce_held", kp.key_held, 1'b0);

    // Two keys on column 3, then one released
    repeat (2) run_frame((one << 3) | (one << 7));
    repeat (3) run_frame(one << 3);
    chk("multi_rel_code", kp.key_code, 4'b0011);
    repeat (3) run_frame(16'h0000);

    // Accept, release, re-press of (3,0)
    repeat (3) run_frame(one << 12);
    repeat (3) run_frame(16'h0000);
    chk("release_code", kp.key_code, 4'b1100);
    repeat (3) run_frame(one << 12);
    repeat (3) run_frame(16'h0000);

    // Random runs of none / single / double patterns
    for (int s = 0; s < 14; s++) begin
      case ($urandom_range(0, 3))
        0:       pat = 16'h0000;
        1, 2:    pat = one << $urandom_range(0, 15);
        default: pat = (one << $urandom_range(0, 15)) | (one << $urandom_range(0, 15));
      endcase
      repeat ($urandom_range(1, 5)) run_frame(pat);
    end
    repeat (3) run_frame(16'h0000);

    // Reset during the second frame of a held (1,2)
    keys = one << 6;
    apply_reset(2);
    run_frame(one << 6);
    repeat (20) begin @(posedge clk); edges++; end
    apply_reset(5);
    repeat (3) run_frame(one << 6);
    chk("post_rst_code", kp.key_code, 4'b0110);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
